// File: rtl/uart_tx_arb.sv
// Two-port round-robin arbiter/sequencer feeding a single uart_byte_tx.
// One byte per grant: accept, pulse send_en, wait for tx_done, then an optional idle gap.
module uart_tx_arb #(
  parameter int GAP_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [7:0]       req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_data,
  output logic             req1_ready,
  input  logic [2:0]       baud_cfg,
  input  logic [GAP_W-1:0] gap_cycles,
  output logic [7:0]       data_byte,
  output logic             send_en,
  output logic [2:0]       baud_set,
  input  logic             tx_done,
  input  logic             uart_state,
  output logic             busy,
  output logic             grant_id,
  output logic [CNT_W-1:0] sent_cnt0,
  output logic [CNT_W-1:0] sent_cnt1
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE,
    GAP
  } state_t;

  state_t           state, state_nx;
  logic             last;
  logic             sel;
  logic             accept;
  logic [GAP_W-1:0] gap_cnt;

  always_comb begin
    sel        = 1'b0;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    state_nx   = state;

    // Both valid: the port that did not win last time gets the grant.
    if (req0_valid && req1_valid) sel = ~last;
    else                          sel = req1_valid;

    accept     = (state == IDLE) && !uart_state && (req0_valid || req1_valid);
    req0_ready = accept && !sel;
    req1_ready = accept && sel;

    send_en = (state == START);
    busy    = (state != IDLE);

    case (state)
      IDLE:      if (accept) state_nx = START;
      START:     state_nx = WAIT_DONE;
      WAIT_DONE: if (tx_done) state_nx = (gap_cycles != '0) ? GAP : IDLE;
      GAP:       if (gap_cnt <= GAP_W'(1)) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_byte <= '0;
      baud_set  <= '0;
      grant_id  <= 1'b0;
      last      <= 1'b1;
      gap_cnt   <= '0;
      sent_cnt0 <= '0;
      sent_cnt1 <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          data_byte <= sel ? req1_data : req0_data;
          baud_set  <= baud_cfg;
          grant_id  <= sel;
          last      <= sel;
        end
        WAIT_DONE: if (tx_done) begin
          gap_cnt <= gap_cycles;
          if (grant_id) sent_cnt1 <= sent_cnt1 + CNT_W'(1);
          else          sent_cnt0 <= sent_cnt0 + CNT_W'(1);
        end
        GAP:     gap_cnt <= gap_cnt - GAP_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: behavioural byte-transmitter model, readiness vector table,
// and a scoreboard of expected (port, byte, baud) checked at each send_en pulse.
module tb_uart_tx_arb;

  localparam int GAP_W = 16;
  localparam int CNT_W = 16;
  localparam int BT    = 12;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0]       req0_data = '0, req1_data = '0;
  logic             req0_ready, req1_ready;
  logic [2:0]       baud_cfg = '0;
  logic [GAP_W-1:0] gap_cycles = '0;
  logic [7:0]       data_byte;
  logic             send_en;
  logic [2:0]       baud_set;
  logic             tx_done, uart_state;
  logic             busy, grant_id;
  logic [CNT_W-1:0] sent_cnt0, sent_cnt1;

  logic model_done, model_busy, spur_done = 1'b0, force_busy = 1'b0;
  int   tcnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       port;
    logic [7:0] data;
    logic [2:0] baud;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic v0, v1, us;
    logic r0, r1;
  } vec_t;
  vec_t vecs[6];

  logic outstanding;

  assign tx_done    = model_done | spur_done;
  assign uart_state = model_busy | force_busy;

  always #10 clk = ~clk;

  uart_tx_arb #(.GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .baud_cfg(baud_cfg), .gap_cycles(gap_cycles),
    .data_byte(data_byte), .send_en(send_en), .baud_set(baud_set),
    .tx_done(tx_done), .uart_state(uart_state),
    .busy(busy), .grant_id(grant_id),
    .sent_cnt0(sent_cnt0), .sent_cnt1(sent_cnt1)
  );

  // Byte transmitter stand-in: busy for BT clocks after send_en, then a one-cycle tx_done.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_busy <= 1'b0;
      model_done <= 1'b0;
      tcnt       <= 0;
    end else begin
      model_done <= 1'b0;
      if (send_en) begin
        model_busy <= 1'b1;
        tcnt       <= BT;
      end else if (model_busy) begin
        if (tcnt == 1) begin
          model_done <= 1'b1;
          model_busy <= 1'b0;
        end
        tcnt <= tcnt - 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timed out", nm);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding <= 1'b0;
    end else if (send_en) begin
      chk("send_en_without_tx_done", 32'(outstanding), 32'd0);
      outstanding <= 1'b1;
      if (sb.size() == 0) begin
        timeout("scoreboard_empty_at_send_en");
      end else begin
        mon_e = sb.pop_front();
        chk("sb_grant_id", 32'(grant_id), 32'(mon_e.port));
        chk("sb_data_byte", 32'(data_byte), 32'(mon_e.data));
        chk("sb_baud_set", 32'(baud_set), 32'(mon_e.baud));
      end
    end else if (model_done) begin
      outstanding <= 1'b0;
    end
  end

  task automatic wait_done(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!model_done && n < 200);
    if (!model_done) timeout(nm);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push(input logic p, input logic [7:0] d, input logic [2:0] b);
    exp_t e;
    e.port = p;
    e.data = d;
    e.baud = b;
    sb.push_back(e);
  endtask

  initial begin
    int n, hs;
    vecs[0] = '{v0:0, v1:0, us:0, r0:0, r1:0};
    vecs[1] = '{v0:1, v1:0, us:0, r0:1, r1:0};
    vecs[2] = '{v0:0, v1:1, us:0, r0:0, r1:1};
    vecs[3] = '{v0:1, v1:1, us:0, r0:1, r1:0};
    vecs[4] = '{v0:1, v1:1, us:1, r0:0, r1:0};
    vecs[5] = '{v0:0, v1:1, us:1, r0:0, r1:0};

    // Reset state
    @(negedge clk);
    chk("reset_outputs", 32'({busy, send_en, req0_ready, req1_ready, grant_id, data_byte, baud_set}), 32'd0);
    chk("reset_counts", {sent_cnt1, sent_cnt0}, 32'd0);
    rst_n = 1'b1;

    // Readiness table in IDLE with last=1; valids withdrawn before the clock edge
    foreach (vecs[i]) begin
      @(negedge clk);
      req0_valid = vecs[i].v0;
      req1_valid = vecs[i].v1;
      force_busy = vecs[i].us;
      #1;
      chk($sformatf("vec%0d_ready0", i), 32'(req0_ready), 32'(vecs[i].r0));
      chk($sformatf("vec%0d_ready1", i), 32'(req1_ready), 32'(vecs[i].r1));
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      force_busy = 1'b0;
    end
    @(negedge clk);
    chk("table_no_accept", 32'(busy), 32'd0);

    // Single byte from port 0
    do_reset();
    req0_valid = 1'b1;
    req0_data  = 8'h1D;
    push(1'b0, 8'h1D, 3'd0);
    #1 chk("single_ready0", 32'({req0_ready, req1_ready}), 32'b10);
    @(negedge clk);
    req0_valid = 1'b0;
    chk("single_send_en_latency", 32'(send_en), 32'd1);
    chk("single_ready_drop", 32'(req0_ready), 32'd0);
    wait_done("single_tx_done");
    @(negedge clk);
    chk("single_busy", 32'(busy), 32'd0);
    chk("single_cnt0", 32'(sent_cnt0), 32'd1);

    // Both ports continuously valid, 4 bytes
    do_reset();
    req0_valid = 1'b1; req0_data = 8'h1D;
    req1_valid = 1'b1; req1_data = 8'h69;
    push(1'b0, 8'h1D, 3'd0); push(1'b1, 8'h69, 3'd0);
    push(1'b0, 8'h1D, 3'd0); push(1'b1, 8'h69, 3'd0);
    hs = 0;
    for (n = 0; n < 400 && hs < 4; n++) begin
      #1;
      if (req0_ready || req1_ready) begin
        hs++;
        if (hs == 4) begin
          @(posedge clk);
          #1;
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    if (hs < 4) timeout("rr_handshakes");
    wait_done("rr_last_done");
    @(negedge clk);
    chk("rr_cnt0", 32'(sent_cnt0), 32'd2);
    chk("rr_cnt1", 32'(sent_cnt1), 32'd2);
    chk("rr_sb_empty", 32'(sb.size()), 32'd0);

    // Inter-byte gap of 100 clocks; gap_cycles changed during the gap applies only to the next byte
    do_reset();
    gap_cycles = 16'd100;
    baud_cfg   = 3'd2;
    req0_valid = 1'b1; req0_data = 8'hA5;
    req1_valid = 1'b1; req1_data = 8'h3C;
    push(1'b0, 8'hA5, 3'd2); push(1'b1, 8'h3C, 3'd2);
    #1 chk("gap_first_grant", 32'({req0_ready, req1_ready}), 32'b10);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    wait_done("gap_done1");
    n = 0;
    do begin
      @(negedge clk);
      n++;
      gap_cycles = 16'd7;
    end while (!req1_ready && n < 300);
    chk("gap_len_100", 32'(n), 32'd101);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    @(negedge clk);
    chk("gap_send_en_next", 32'(send_en), 32'd1);
    wait_done("gap_done2");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 300);
    chk("gap_len_7", 32'(n), 32'd8);
    chk("gap_counts", {sent_cnt1, sent_cnt0}, {16'd1, 16'd1});

    // baud_cfg changed mid-byte
    do_reset();
    gap_cycles = '0;
    baud_cfg   = 3'd0;
    req0_valid = 1'b1; req0_data = 8'h11;
    push(1'b0, 8'h11, 3'd0);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    repeat (4) @(negedge clk);
    baud_cfg = 3'd3;
    @(negedge clk);
    chk("baud_hold_wait", 32'(baud_set), 32'd0);
    wait_done("baud_done1");
    @(negedge clk);
    chk("baud_hold_idle", 32'(baud_set), 32'd0);
    req1_valid = 1'b1; req1_data = 8'h22;
    push(1'b1, 8'h22, 3'd3);
    #1 chk("baud_ready1", 32'(req1_ready), 32'd1);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    @(negedge clk);
    chk("baud_new", 32'(baud_set), 32'd3);
    wait_done("baud_done2");
    @(negedge clk);

    // Spurious tx_done in IDLE and in START
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    chk("spur_idle_state", 32'(busy), 32'd0);
    chk("spur_idle_counts", {sent_cnt1, sent_cnt0}, {16'd1, 16'd1});
    req0_valid = 1'b1; req0_data = 8'h44;
    push(1'b0, 8'h44, 3'd3);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    @(negedge clk);
    spur_done = 1'b1;
    chk("spur_start_send_en", 32'(send_en), 32'd1);
    @(negedge clk);
    spur_done = 1'b0;
    chk("spur_start_busy", 32'(busy), 32'd1);
    chk("spur_start_cnt0", 32'(sent_cnt0), 32'd1);
    wait_done("spur_real_done");
    @(negedge clk);
    chk("spur_real_cnt0", 32'(sent_cnt0), 32'd2);

    // Asynchronous reset during WAIT_DONE, then port 1 alone
    req0_valid = 1'b1; req0_data = 8'h55;
    push(1'b0, 8'h55, 3'd3);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", 32'({busy, send_en, req0_ready, req1_ready, grant_id, data_byte, baud_set}), 32'd0);
    chk("rst_async_counts", {sent_cnt1, sent_cnt0}, 32'd0);
    @(negedge clk);
    baud_cfg = 3'd5;
    req1_valid = 1'b1; req1_data = 8'h77;
    push(1'b1, 8'h77, 3'd5);
    rst_n = 1'b1;
    #1;
    chk("rst_release_send_en", 32'(send_en), 32'd0);
    chk("rst_release_ready1", 32'({req0_ready, req1_ready}), 32'b01);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    @(negedge clk);
    chk("rst_p1_send_en", 32'(send_en), 32'd1);
    wait_done("rst_p1_done");
    @(negedge clk);
    chk("rst_p1_counts", {sent_cnt1, sent_cnt0}, {16'd1, 16'd0});
    chk("rst_p1_grant", 32'({grant_id, busy}), 32'b10);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
